des_pipe_engine: RTL and testbench
==================================

# des_pipe_engine

Parametrised successor to the fixed 16-stage DES encryption pipeline. It performs DES encryption or decryption with a per-beat mode bit and a configurable round count. Rounds can be grouped per register stage, and a user tag travels with each beat. It adds valid/ready backpressure, synchronous flush and an in-flight counter, and it sits between the key schedule and the test/attack datapath.

## Interface

**Parameters**
- NUM_ROUNDS, 16: Feistel rounds executed, 1..16.
- ROUNDS_PER_STAGE, 1: rounds between pipeline registers; must divide NUM_ROUNDS. Stage count S = NUM_ROUNDS/ROUNDS_PER_STAGE.
- TAG_W, 4: width of sideband tag.

**Ports**
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous; drops all in-flight beats.
- in_valid, input, 1: beat offered.
- in_ready, output, 1: beat accepted when in_valid && in_ready.
- in_decrypt, input, 1: 0 = encrypt, 1 = decrypt.
- in_tag, input, TAG_W: sideband, returned unchanged.
- message, input, [1:64]: input block, DES bit order (bit 1 = MSB).
- round_keys, input, [1:48*NUM_ROUNDS]: K_i = bits 48(i-1)+1 .. 48i. Quasi-static.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- result, output, [1:64]: output block.
- out_tag, output, TAG_W: tag of the result beat.
- out_decrypt, output, 1: mode of the result beat.
- in_flight, output, clog2(S+1): beats currently held in the pipe.

## Operation
- The IP is applied combinationally before stage 1. The FP is applied combinationally after stage S.
- Each stage applies ROUNDS_PER_STAGE rounds. Global round index j runs 1..NUM_ROUNDS.
- Round j uses K_j in encrypt mode and K_(NUM_ROUNDS+1-j) in decrypt mode. Selection is driven by the beat's own registered mode bit, so mixed modes in flight are legal.
- After the last round, the halves are swapped (R_n‖L_n) before FP, for any NUM_ROUNDS.
- round_keys must be stable while in_flight ≠ 0. Changing it mid-flight is undefined for in-flight beats only.
- Stall is global: stall = out_valid && !out_ready. in_ready = !stall && !flush.
- While stall is high, all stage registers (data, valid, tag, mode) hold.
- Flush has priority over acceptance and stall:
  - Next cycle, all valid bits are 0 and in_flight = 0.
  - Data registers need not clear.
- in_flight bookkeeping:
  - +1 on accept, −1 on out_valid && out_ready.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds S.

## Timing
- Reset values: out_valid 0, in_flight 0, all valid bits 0, in_ready 1 after reset. result, out_tag and out_decrypt reset to 0.
- Reset asserted mid-operation discards all beats immediately (asynchronous).
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S−1, i.e. S cycles with no stall. It is observable in the cycle following edge t+S−1.
- Throughput: 1 beat/cycle while out_ready = 1.
- Each stall cycle adds exactly one cycle of latency to every in-flight beat. No beat is lost or duplicated.
- Output ordering equals input ordering.
- Full condition: in_flight = S with the output stalled. in_ready is then low.
- With out_ready = 0, out_valid, result, out_tag and out_decrypt are held constant until the handshake.
- in_valid while in_ready = 0: the beat is not accepted, and the source must hold it.

## Structure
- Package des_pkg holds:
  - IP, FP, E, P tables.
  - S-box table (8×64×4).
  - Functions: initial_perm, final_perm, expand, permute_p, sbox_sub.
  - Constant DES_BLK = 64 and DES_KEY_W = 48.
- Sub-module des_round: one combinational Feistel round. Inputs L, R, K; outputs L', R'.
- Each stage instantiates ROUNDS_PER_STAGE des_round copies via generate.
- Top level holds the stage registers, key-index mux, stall/flush control and the in_flight counter.

## Test plan
- **FIPS vector, encrypt:**
  - Stimulus: default params; K_i from key 133457799BBCDFF1; message 0123456789ABCDEF, decrypt 0, tag 5.
  - Required: after 16 cycles, result 85E813540F0AB405, out_tag 5.
- **FIPS vector, decrypt:**
  - Stimulus: same keys; message 85E813540F0AB405, decrypt 1.
  - Required: result 0123456789ABCDEF, out_decrypt 1.
- **Zero vector, regrouped stages:**
  - Stimulus: ROUNDS_PER_STAGE = 4; all-zero key and message.
  - Required: result 8CA64DE9C1B123A7 after 4 cycles.
- **Streaming with backpressure:**
  - Stimulus: 40 back-to-back beats with alternating modes and tags 0..15 (wrapping). Toggle out_ready pseudo-randomly.
  - Required: every result matches the software model, in order. in_flight never exceeds 16, and in_ready is low exactly when stalled.
- **Flush:**
  - Stimulus: fill 10 beats, assert flush for 1 cycle together with in_valid.
  - Required: next cycle in_flight 0 and out_valid 0. The flush-cycle beat is not accepted. The next accepted beat emerges 16 cycles later.
- **Async reset mid-stream:**
  - Stimulus: drop rst_n mid-stream between clock edges.
  - Required: out_valid and in_flight go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables and the bit-permutation / substitution helpers.
// Blocks are held as [63:0] vectors; bit 63 is DES bit 1 (the MSB).
package des_pkg;

    localparam int DES_BLK   = 64;
    localparam int DES_KEY_W = 48;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry index = {row, col} = row*16 + col.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] initial_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
        return y;
    endfunction

    function automatic logic [63:0] final_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - FP_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], r[5'(32 - E_T[i])]};
        return y;
    endfunction

    function automatic logic [31:0] permute_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y = {y[30:0], x[5'(32 - P_T[i])]};
        return y;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four bits the column.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        y = '0;
        for (int k = 0; k < 8; k++) begin
            b = x[6'(47 - 6 * k) -: 6];
            y = {y[27:0], 4'(SBOX[3'(k)][{b[5], b[0], b[4:1]}])};
        end
        return y;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
    import des_pkg::*;
(
    input  logic [31:0]          i_l,
    input  logic [31:0]          i_r,
    input  logic [DES_KEY_W-1:0] i_k,
    output logic [31:0]          o_l,
    output logic [31:0]          o_r
);

    logic [31:0] w_f;

    assign w_f = permute_p(sbox_sub(expand(i_r) ^ i_k));
    assign o_l = i_r;
    assign o_r = i_l ^ w_f;

endmodule

// File: rtl/des_pipe_engine.sv
// Pipelined DES encrypt/decrypt engine with per-beat mode, sideband tag,
// global-stall backpressure, synchronous flush and an in-flight counter.
module des_pipe_engine
    import des_pkg::*;
#(
    parameter  int NUM_ROUNDS       = 16,
    parameter  int ROUNDS_PER_STAGE = 1,
    parameter  int TAG_W            = 4,
    localparam int S                = NUM_ROUNDS / ROUNDS_PER_STAGE,
    localparam int CNT_W            = $clog2(S + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_decrypt,
    input  logic [TAG_W-1:0]                  in_tag,
    input  logic [DES_BLK-1:0]                message,
    input  logic [DES_KEY_W*NUM_ROUNDS-1:0]   round_keys,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DES_BLK-1:0]                result,
    output logic [TAG_W-1:0]                  out_tag,
    output logic                              out_decrypt,
    output logic [CNT_W-1:0]                  in_flight
);

    logic             w_stall, w_accept, w_deq;
    logic [63:0]      w_ip;

    logic [31:0]      r_l     [S];
    logic [31:0]      r_r     [S];
    logic             r_valid [S];
    logic [TAG_W-1:0] r_tag   [S];
    logic             r_dec   [S];
    logic [CNT_W-1:0] r_in_flight;

    logic             w_vin  [S];
    logic [TAG_W-1:0] w_tin  [S];
    logic             w_min  [S];
    logic [31:0]      w_lout [S];
    logic [31:0]      w_rout [S];

    assign w_stall  = r_valid[S-1] && !out_ready;
    assign in_ready = !w_stall && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_deq    = r_valid[S-1] && out_ready;
    assign w_ip     = initial_perm(message);

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        logic [31:0] w_l [ROUNDS_PER_STAGE+1];
        logic [31:0] w_r [ROUNDS_PER_STAGE+1];

        if (gi == 0) begin : g_head
            assign w_vin[gi] = w_accept;
            assign w_tin[gi] = in_tag;
            assign w_min[gi] = in_decrypt;
            assign w_l[0]    = w_ip[63:32];
            assign w_r[0]    = w_ip[31:0];
        end else begin : g_body
            assign w_vin[gi] = r_valid[gi-1];
            assign w_tin[gi] = r_tag[gi-1];
            assign w_min[gi] = r_dec[gi-1];
            assign w_l[0]    = r_l[gi-1];
            assign w_r[0]    = r_r[gi-1];
        end

        // Decrypt walks the key schedule backwards: round J uses K_(N+1-J).
        for (genvar gr = 0; gr < ROUNDS_PER_STAGE; gr++) begin : g_round
            localparam int J = gi * ROUNDS_PER_STAGE + gr + 1;
            logic [DES_KEY_W-1:0] w_key;

            assign w_key = w_min[gi]
                ? round_keys[DES_KEY_W*J-1 -: DES_KEY_W]
                : round_keys[DES_KEY_W*(NUM_ROUNDS-J+1)-1 -: DES_KEY_W];

            des_round u_round (
                .i_l (w_l[gr]),
                .i_r (w_r[gr]),
                .i_k (w_key),
                .o_l (w_l[gr+1]),
                .o_r (w_r[gr+1])
            );
        end

        assign w_lout[gi] = w_l[ROUNDS_PER_STAGE];
        assign w_rout[gi] = w_r[ROUNDS_PER_STAGE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) begin
                r_valid[s] <= 1'b0;
                r_l[s]     <= '0;
                r_r[s]     <= '0;
                r_tag[s]   <= '0;
                r_dec[s]   <= 1'b0;
            end
        end else if (flush) begin
            for (int s = 0; s < S; s++) r_valid[s] <= 1'b0;
        end else if (!w_stall) begin
            for (int s = 0; s < S; s++) begin
                r_valid[s] <= w_vin[s];
                r_l[s]     <= w_lout[s];
                r_r[s]     <= w_rout[s];
                r_tag[s]   <= w_tin[s];
                r_dec[s]   <= w_min[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
        end else if (flush) begin
            r_in_flight <= '0;
        end else if (w_accept && !w_deq) begin
            r_in_flight <= r_in_flight + CNT_W'(1);
        end else if (!w_accept && w_deq) begin
            r_in_flight <= r_in_flight - CNT_W'(1);
        end
    end

    // Halves are swapped after the last round before the final permutation.
    assign result      = final_perm({r_r[S-1], r_l[S-1]});
    assign out_valid   = r_valid[S-1];
    assign out_tag     = r_tag[S-1];
    assign out_decrypt = r_dec[S-1];
    assign in_flight   = r_in_flight;

endmodule

// File: tb/tb_des_pipe_engine.sv
// Self-checking bench for des_pipe_engine: known-answer table, scoreboarded
// streaming with backpressure, full/flush/async-reset sequences.
module tb_des_pipe_engine;
    import des_pkg::*;

    localparam int N = 16;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              flush, in_valid, in_ready, in_decrypt;
    logic              out_valid, out_ready, out_decrypt;
    logic [3:0]        in_tag, out_tag;
    logic [63:0]       message, result;
    logic [48*N-1:0]   round_keys;
    logic [4:0]        in_flight;

    logic              b_flush, b_in_valid, b_in_ready, b_in_decrypt;
    logic              b_out_valid, b_out_ready, b_out_decrypt;
    logic [3:0]        b_in_tag, b_out_tag;
    logic [63:0]       b_msg, b_result;
    logic [48*N-1:0]   b_keys;
    logic [2:0]        b_in_flight;

    des_pipe_engine #(.NUM_ROUNDS(16), .ROUNDS_PER_STAGE(1), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .in_tag(in_tag), .message(message), .round_keys(round_keys),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .out_decrypt(out_decrypt), .in_flight(in_flight)
    );

    des_pipe_engine #(.NUM_ROUNDS(16), .ROUNDS_PER_STAGE(4), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_decrypt(b_in_decrypt),
        .in_tag(b_in_tag), .message(b_msg), .round_keys(b_keys),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
        .out_tag(b_out_tag), .out_decrypt(b_out_decrypt), .in_flight(b_in_flight)
    );

    typedef struct { logic [63:0] res; logic [3:0] tag; logic dec; } exp_t;
    typedef struct { logic [63:0] msg; logic dec; logic [3:0] tag; logic [63:0] exp; } vec_t;

    exp_t        sb [$];
    vec_t        vecs [3];
    logic [47:0] ks [16];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        acc, got, prev_stall;
    logic [63:0] got_res, prev_res;
    logic [3:0]  got_tag, prev_tag;
    logic        got_dec, prev_dec;
    logic [63:0] cur;
    int          lat, i, cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic gen_keys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        cd = '0;
        for (int b = 0; b < 56; b++) cd = {cd[54:0], key[6'(64 - PC1[b])]};
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            k  = '0;
            for (int b = 0; b < 48; b++) k = {k[46:0], cd[6'(56 - PC2[b])]};
            ks[r] = k;
        end
        for (int r = 0; r < 16; r++) round_keys = {round_keys[48*15-1:0], ks[r]};
    endtask

    function automatic logic [63:0] model(input logic [63:0] m, input logic dec);
        logic [63:0] ip;
        logic [31:0] l, r, f;
        logic [47:0] k;
        ip = initial_perm(m);
        l  = ip[63:32];
        r  = ip[31:0];
        for (int j = 0; j < 16; j++) begin
            k = dec ? ks[15 - j] : ks[j];
            f = permute_p(sbox_sub(expand(r) ^ k));
            {l, r} = {r, l ^ f};
        end
        return final_perm({r, l});
    endfunction

    // Called at a falling edge after inputs are driven; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_valid",  64'(out_valid),   64'd1);
            chk("hold_result", result,           prev_res);
            chk("hold_tag",    64'(out_tag),     64'(prev_tag));
            chk("hold_dec",    64'(out_decrypt), 64'(prev_dec));
        end
        chk("in_ready",     64'(in_ready),  64'(!flush && !(out_valid && !out_ready)));
        chk("in_flight",    64'(in_flight), 64'(sb.size()));
        chk("in_flight_max", 64'(in_flight <= 5'd16), 64'd1);
        got = 1'b0;
        if (out_valid && out_ready) begin
            got     = 1'b1;
            got_res = result;
            got_tag = out_tag;
            got_dec = out_decrypt;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got result %h, expected no output", result);
            end else begin
                e = sb.pop_front();
                chk("sb_result", result,           e.res);
                chk("sb_tag",    64'(out_tag),     64'(e.tag));
                chk("sb_dec",    64'(out_decrypt), 64'(e.dec));
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back('{model(message, in_decrypt), in_tag, in_decrypt});
        prev_stall = out_valid && !out_ready && !flush;
        prev_res   = result;
        prev_tag   = out_tag;
        prev_dec   = out_decrypt;
        if (flush) sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_out();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            lat++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 4'd5,  64'h85E813540F0AB405};
        vecs[1] = '{64'h85E813540F0AB405, 1'b1, 4'd9,  64'h0123456789ABCDEF};
        vecs[2] = '{64'h0123456789ABCDEF, 1'b0, 4'd15, 64'h85E813540F0AB405};
        round_keys = '0;
        gen_keys(64'h133457799BBCDFF1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
        in_tag = '0; message = '0; out_ready = 1'b1; prev_stall = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_decrypt = 1'b0; b_in_tag = 4'd3;
        b_msg = '0; b_keys = '0; b_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_in_flight",   64'(in_flight),   64'd0);
        chk("rst_in_ready",    64'(in_ready),    64'd1);
        chk("rst_result",      result,           64'd0);
        chk("rst_out_tag",     64'(out_tag),     64'd0);
        chk("rst_out_decrypt", 64'(out_decrypt), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer table through the 16-stage pipe.
        for (int v = 0; v < 3; v++) begin
            message = vecs[v].msg; in_decrypt = vecs[v].dec; in_tag = vecs[v].tag;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("kat_accept", 64'(acc), 64'd1);
            wait_out();
            chk("kat_latency", 64'(lat),     64'd16);
            chk("kat_result",  got_res,      vecs[v].exp);
            chk("kat_tag",     64'(got_tag), 64'(vecs[v].tag));
            chk("kat_dec",     64'(got_dec), 64'(vecs[v].dec));
        end

        // Zero key/message through the 4-stage grouping.
        b_in_valid = 1'b1;
        #1 chk("b_in_ready", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            lat++;
            #1;
            if (b_out_valid) break;
            @(negedge clk);
        end
        chk("b_latency",   64'(lat),         64'd4);
        chk("b_result",    b_result,         64'h8CA64DE9C1B123A7);
        chk("b_tag",       64'(b_out_tag),   64'd3);
        chk("b_in_flight", 64'(b_in_flight), 64'd1);
        @(negedge clk);

        // Streaming, alternating modes, random backpressure.
        i = 0; cyc = 0;
        cur = {$urandom, $urandom};
        while (i < 40 && cyc < 2000) begin
            message = cur; in_decrypt = i[0]; in_tag = 4'(i % 16); in_valid = 1'b1;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
            if (acc) begin
                i++;
                cur = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_sent", 64'(i), 64'd40);
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin tick(); cyc++; end
        chk("stream_drain", 64'(sb.size()), 64'd0);

        // Fill to the full condition with the output stalled.
        out_ready = 1'b0; cur = {$urandom, $urandom};
        for (int k = 0; k < 24; k++) begin
            message = cur; in_decrypt = 1'(k); in_tag = 4'(k); in_valid = 1'b1;
            tick();
            if (acc) cur = {$urandom, $urandom};
        end
        #1;
        chk("full_in_flight", 64'(in_flight), 64'd16);
        chk("full_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin tick(); cyc++; end
        chk("full_drain", 64'(sb.size()), 64'd0);

        // Flush with a beat offered in the same cycle.
        for (int k = 0; k < 10; k++) begin
            message = {$urandom, $urandom}; in_decrypt = 1'(k); in_tag = 4'(k); in_valid = 1'b1;
            tick();
        end
        message = 64'h0123456789ABCDEF; in_decrypt = 1'b0; in_tag = 4'd7; flush = 1'b1;
        tick();
        chk("flush_no_accept", 64'(acc), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_flight", 64'(in_flight), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out();
        chk("flush_next_latency", 64'(lat), 64'd16);
        chk("flush_next_result",  got_res,  64'h85E813540F0AB405);

        // Asynchronous reset between clock edges mid-stream.
        for (int k = 0; k < 20; k++) begin
            message = {$urandom, $urandom}; in_decrypt = 1'(k); in_tag = 4'(k); in_valid = 1'b1;
            tick();
        end
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_flight", 64'(in_flight), 64'd0);
        in_valid = 1'b0; sb.delete(); prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
